// File: rtl/mult_div_if.sv
// Start/result bus between the multicycle control unit and mult_div_unit.
// MULTDIV_UNSIGNED_EN adds the Unsigned qualifier sampled with the start pulse.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    // Handshake: a one-cycle MultOp/DivOp pulse seen while busy=0 and the unit is
    // idle starts an operation; starts while busy are dropped, not queued. The
    // result is valid in HI/LO during the single cycle done=1 and held afterwards.
`ifdef MULTDIV_UNSIGNED_EN
    logic             Unsigned;
`endif
    logic             MultOp;
    logic             DivOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             DivZero;

    modport master (
`ifdef MULTDIV_UNSIGNED_EN
        output Unsigned,
`endif
        output MultOp, DivOp, A, B,
        input  HI, LO, busy, done, DivZero
    );

    modport slave (
`ifdef MULTDIV_UNSIGNED_EN
        input  Unsigned,
`endif
        input  MultOp, DivOp, A, B,
        output HI, LO, busy, done, DivZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / restoring divide feeding HI/LO.
// Optional macro MULTDIV_UNSIGNED_EN enables multu/divu via bus.Unsigned.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clock,
    input  logic        RESET_in,
    mult_div_if.slave   bus,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

    state_t             state, state_nx;
    logic               op_mul, is_sgn, neg_q, neg_r, zflag, b_msb;
    logic [WIDTH:0]     acc, mcand;
    logic [WIDTH-1:0]   q;
    logic               q_1;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               done_r, dz_r;

    logic               start, start_mul, uns_in, a_neg, b_neg, b_zero, last_iter;
    logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULTDIV_UNSIGNED_EN
    assign uns_in = bus.Unsigned;
`else
    assign uns_in = 1'b0;
`endif

    assign start     = bus.MultOp | bus.DivOp;
    assign start_mul = bus.MultOp;
    assign a_neg     = ~uns_in & bus.A[WIDTH-1];
    assign b_neg     = ~uns_in & bus.B[WIDTH-1];
    assign a_mag     = a_neg ? (~bus.A + 1'b1) : bus.A;
    assign b_mag     = b_neg ? (~bus.B + 1'b1) : bus.B;
    assign b_zero    = (bus.B == '0);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock or posedge RESET_in) begin
        if (RESET_in) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (!start_mul && b_zero) ? FINISH : RUN;
            RUN:     if (last_iter) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Booth step: add/sub on a WIDTH+1 accumulator so the most negative operand
    // cannot overflow, then arithmetic shift of {acc, q, q_1}.
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH+1:0] div_shift, div_diff;
    logic             div_ok;

    always_comb begin
        booth_sum = acc;
        case ({q[0], q_1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
        div_shift = {acc, q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand};
        div_ok    = ~div_diff[WIDTH+1];
    end

    // Unsigned multiply runs the signed recurrence; a set multiplier MSB means
    // the true multiplier is 2^WIDTH larger, so add the multiplicand to HI.
    logic [WIDTH-1:0] mul_hi, div_q, div_r;
    assign mul_hi = acc[WIDTH-1:0] + ((!is_sgn && b_msb) ? mcand[WIDTH-1:0] : '0);
    assign div_q  = neg_q ? (~q + 1'b1) : q;
    assign div_r  = neg_r ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];

    always_ff @(posedge clock or posedge RESET_in) begin
        if (RESET_in) begin
            op_mul <= 1'b0;
            is_sgn <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            zflag  <= 1'b0;
            b_msb  <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            q      <= '0;
            q_1    <= 1'b0;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_mul <= start_mul;
                        is_sgn <= ~uns_in;
                        zflag  <= !start_mul && b_zero;
                        b_msb  <= bus.B[WIDTH-1];
                        cnt    <= '0;
                        acc    <= '0;
                        q_1    <= 1'b0;
                        if (start_mul) begin
                            mcand <= {a_neg, bus.A};
                            q     <= bus.B;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            mcand <= {1'b0, b_mag};
                            q     <= a_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op_mul) begin
                        acc <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                        q   <= {booth_sum[0], q[WIDTH-1:1]};
                        q_1 <= q[0];
                    end else begin
                        acc <= div_ok ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
                        q   <= {q[WIDTH-2:0], div_ok};
                    end
                end
                FINISH: begin
                    done_r <= 1'b1;
                    dz_r   <= zflag;
                    zflag  <= 1'b0;
                    if (!zflag) begin
                        if (op_mul) begin
                            hi_r <= mul_hi;
                            lo_r <= q;
                        end else begin
                            hi_r <= div_r;
                            lo_r <= div_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.HI      = hi_r;
    assign bus.LO      = lo_r;
    assign bus.busy    = (state == RUN);
    assign bus.done    = done_r;
    assign bus.DivZero = dz_r;
    assign dbg_state   = state;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, corner operands,
// divide-by-zero, ignored restarts and mid-operation reset.
module tb_mult_div_unit;
    localparam int W = 32;

    logic       clock = 1'b0;
    logic       RESET_in;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         errors = 0;

    mult_div_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock     (clock),
        .RESET_in  (RESET_in),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse a start for one edge, then wait (bounded) for done.
    task automatic run_op(input bit mul, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int edges, output int busy_cycles, output bit got_done);
        @(negedge clock);
        bus.MultOp = mul;
        bus.DivOp  = ~mul;
        bus.A      = a;
        bus.B      = b;
        @(posedge clock);
        #1;
        bus.MultOp  = 1'b0;
        bus.DivOp   = 1'b0;
        edges       = 0;
        busy_cycles = bus.busy ? 1 : 0;
        got_done    = 1'b0;
        while (!got_done && edges < 100) begin
            @(posedge clock);
            #1;
            edges++;
            if (bus.done) got_done = 1'b1;
            else if (bus.busy) busy_cycles++;
        end
    endtask

    task automatic check_result(input string name, input bit got_done,
                                input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL %s_done: done=0 within budget, required 1", name);
        end
        checks++;
        if (bus.HI !== exp_hi) begin
            errors++;
            $display("FAIL %s_hi: got %h required %h", name, bus.HI, exp_hi);
        end
        checks++;
        if (bus.LO !== exp_lo) begin
            errors++;
            $display("FAIL %s_lo: got %h required %h", name, bus.LO, exp_lo);
        end
    endtask

    task automatic test_reset();
        RESET_in   = 1'b1;
        bus.MultOp = 1'b0;
        bus.DivOp  = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        RESET_in = 1'b0;
        #1;
        checks++;
        if ({bus.HI, bus.LO} !== '0) begin
            errors++;
            $display("FAIL reset_hilo: got %h_%h required 0_0", bus.HI, bus.LO);
        end
        checks++;
        if ({bus.busy, bus.done, bus.DivZero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000", {bus.busy, bus.done, bus.DivZero});
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d required 0", dbg_state);
        end
    endtask

    task automatic test_mult_latency();
        int e, bc;
        bit d;
        run_op(1'b1, 32'd7, 32'hFFFF_FFFD, e, bc, d);
        check_result("mult_7x-3", d, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        checks++;
        if (e !== 33) begin
            errors++;
            $display("FAIL mult_latency: got %0d edges required 33", e);
        end
        checks++;
        if (bc !== 32) begin
            errors++;
            $display("FAIL mult_busy_cycles: got %0d required 32", bc);
        end
        checks++;
        if (bus.DivZero !== 1'b0) begin
            errors++;
            $display("FAIL mult_divzero: got %b required 0", bus.DivZero);
        end
        @(posedge clock);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mult_done_width: got %b required 0", bus.done);
        end
    endtask

    task automatic test_mult_corners();
        logic [W-1:0] va [2];
        logic [W-1:0] vh [2];
        logic [W-1:0] vl [2];
        int e, bc;
        bit d;
        va[0] = 32'h8000_0000; vh[0] = 32'h4000_0000; vl[0] = 32'h0000_0000;
        va[1] = 32'h7FFF_FFFF; vh[1] = 32'h3FFF_FFFF; vl[1] = 32'h0000_0001;
        for (int i = 0; i < 2; i++) begin
            run_op(1'b1, va[i], va[i], e, bc, d);
            check_result($sformatf("mult_sq%0d", i), d, vh[i], vl[i]);
        end
    endtask

    task automatic test_div();
        int e, bc;
        bit d;
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, e, bc, d);
        check_result("div_-7/2", d, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        checks++;
        if (e !== 33) begin
            errors++;
            $display("FAIL div_latency: got %0d edges required 33", e);
        end
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, e, bc, d);
        check_result("div_min/-1", d, 32'h0000_0000, 32'h8000_0000);
        checks++;
        if (bus.DivZero !== 1'b0) begin
            errors++;
            $display("FAIL div_wrap_divzero: got %b required 0", bus.DivZero);
        end
        // 0x451 = 0x22*0x20 + 0x11: also preloads HI/LO for the zero-divisor case
        run_op(1'b0, 32'h0000_0451, 32'h0000_0020, e, bc, d);
        check_result("div_preload", d, 32'h0000_0011, 32'h0000_0022);
    endtask

    task automatic test_div_zero();
        int e, bc;
        bit d;
        run_op(1'b0, 32'd5, 32'd0, e, bc, d);
        check_result("divzero", d, 32'h0000_0011, 32'h0000_0022);
        checks++;
        if (e !== 1) begin
            errors++;
            $display("FAIL divzero_latency: got %0d edges required 1", e);
        end
        checks++;
        if (bus.DivZero !== 1'b1) begin
            errors++;
            $display("FAIL divzero_flag: got %b required 1", bus.DivZero);
        end
        checks++;
        if (bc !== 0) begin
            errors++;
            $display("FAIL divzero_busy: got %0d busy cycles required 0", bc);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({bus.done, bus.DivZero} !== 2'b00) begin
            errors++;
            $display("FAIL divzero_pulse_width: got %b required 00", {bus.done, bus.DivZero});
        end
    endtask

    task automatic test_ignore_start();
        int done_cnt = 0;
        int done_edge = -1;
        int e = 0;
        logic [W-1:0] hi_s = 'x;
        logic [W-1:0] lo_s = 'x;
        @(negedge clock);
        bus.MultOp = 1'b1;
        bus.A      = 32'd3;
        bus.B      = 32'd4;
        @(posedge clock);
        #1;
        bus.MultOp = 1'b0;
        repeat (4) @(posedge clock);
        e = 4;
        @(negedge clock);
        bus.MultOp = 1'b1;
        bus.A      = 32'd9;
        @(posedge clock);
        #1;
        e++;
        bus.MultOp = 1'b0;
        while (e < 80) begin
            @(posedge clock);
            #1;
            e++;
            if (bus.done) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = e;
                    hi_s = bus.HI;
                    lo_s = bus.LO;
                end
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d required 1", done_cnt);
        end
        checks++;
        if (done_edge !== 33) begin
            errors++;
            $display("FAIL ignore_done_edge: got %0d required 33", done_edge);
        end
        checks++;
        if ({hi_s, lo_s} !== {32'd0, 32'd12}) begin
            errors++;
            $display("FAIL ignore_result: got %h_%h required 0_c", hi_s, lo_s);
        end
    endtask

    task automatic test_reset_abort();
        int done_cnt = 0;
        int e, bc;
        bit d;
        @(negedge clock);
        bus.DivOp = 1'b1;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        @(posedge clock);
        #1;
        bus.DivOp = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        RESET_in = 1'b1;
        #1;
        checks++;
        if ({bus.HI, bus.LO} !== '0) begin
            errors++;
            $display("FAIL abort_hilo: got %h_%h required 0_0", bus.HI, bus.LO);
        end
        checks++;
        if ({bus.busy, dbg_state} !== 3'b000) begin
            errors++;
            $display("FAIL abort_busy_state: got %b required 000", {bus.busy, dbg_state});
        end
        @(negedge clock);
        RESET_in = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses required 0", done_cnt);
        end
        run_op(1'b0, 32'd100, 32'd7, e, bc, d);
        check_result("abort_div_100/7", d, 32'd2, 32'd14);
    endtask

    initial begin
`ifdef MULTDIV_UNSIGNED_EN
        bus.Unsigned = 1'b0;
`endif
        test_reset();
        test_mult_latency();
        test_mult_corners();
        test_div();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit; sits directly downstream of the multicycle control unit.
- Started by the control unit's MultOp / DivOp pulses; operands come from register-file outputs A (rs) and B (rt).
- Produces the HI/LO registers read by mfhi/mflo, plus a divide-by-zero exception flag for the exception-routine path.
- Control unit waits in Mult_s/Div_s until `done`, then moves to WriteHILO_s.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- RESET_in  input  1  asynchronous, active-high reset.
- MultOp  input  1  start multiply; sampled only in IDLE.
- DivOp  input  1  start divide; sampled only in IDLE.
- A  input  WIDTH  rs operand: multiplicand / dividend.
- B  input  WIDTH  rt operand: multiplier / divisor.
- HI  output  WIDTH  product[63:32] or remainder.
- LO  output  WIDTH  product[31:0] or quotient.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.
- DivZero  output  1  one-cycle pulse when a divide has B==0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - state=IDLE; HI=LO=0; busy=done=DivZero=0.
  - Internal accumulator, operand and counter registers cleared.
  - An aborted operation never asserts done.
- States: IDLE, RUN, FINISH.
- IDLE:
  - On the edge where MultOp=1 or DivOp=1 (call it edge 0), capture A, B and the op type; counter=0; go to RUN.
  - MultOp and DivOp both high: MultOp wins.
  - DivOp with B==0: do not enter RUN; go to FINISH with the zero flag set.
- RUN:
  - One iteration per edge, edges 1..WIDTH. Counter increments each iteration; after iteration WIDTH go to FINISH.
  - MultOp/DivOp ignored while busy; no queuing.
- FINISH (entered at edge WIDTH, or at edge 0 for divide-by-zero):
  - Next edge commits the result to HI/LO, pulses done=1 for one cycle, then returns to IDLE.
  - Normal op: done high during the cycle after edge WIDTH+1, i.e. result visible 33 edges after edge 0 for WIDTH=32.
  - Divide-by-zero: done and DivZero high together for one cycle after edge 1; HI/LO keep their previous values.
- Multiply:
  - Radix-2 Booth, signed, full 2*WIDTH-bit result.
  - Use a WIDTH+1-bit partial-product adder so A=0x80000000 is correct.
  - Product[63:32] goes to HI, product[31:0] to LO.
- Divide:
  - Restoring division on magnitudes, then sign fix-up.
  - Quotient truncates toward zero; its sign is sign(A) XOR sign(B).
  - Remainder takes the sign of A.
  - Quotient goes to LO, remainder to HI.
  - 0x80000000 / -1: LO=0x80000000, HI=0 (wrap, no exception).
- HI/LO hold their value between operations. They change only on a done cycle or on reset.
- Outputs are registered; no combinational path from inputs to any output.

Optional Feature:
- Macro: MULTDIV_UNSIGNED_EN.
- Defined:
  - Adds port `Unsigned  input  1`, sampled with the start pulse.
  - When Unsigned=1, multiply and divide treat A and B as unsigned (multu/divu): zero-extend in Booth, no sign fix-up.
  - Latency is unchanged.
- Undefined: port absent; all operations signed.

Test Plan:
- MultOp, A=7, B=0xFFFFFFFD (-3) -> busy for 32 cycles; done pulse 33 edges after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MultOp, A=B=0x80000000 -> HI=0x40000000, LO=0x00000000; A=B=0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001.
- DivOp, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); then A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- HI=0x11, LO=0x22 preloaded by a prior op; DivOp, A=5, B=0 -> DivZero=done=1 for one cycle after edge 1; busy never high; HI=0x11, LO=0x22 unchanged.
- Start mult 3*4; pulse MultOp again at iteration 5 with A=9 -> second start ignored; result HI=0, LO=12; single done pulse.
- Start div 100/7; assert RESET_in at iteration 10 -> immediately HI=LO=0, busy=0; no done; after release, div 100/7 -> LO=14, HI=2.
